// File: rtl/filter_coeff_loader.sv
// Double-buffered polyphase coefficient store: streams NUM_TAPS words into the
// shadow bank, swaps banks atomically, and serves NUM_PHASE coefficients per group.
module filter_coeff_loader #(
    parameter int COEF_W    = 11,
    parameter int NUM_TAPS  = 20,
    parameter int NUM_PHASE = 4,
    parameter int NUM_GROUP = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic              coef_valid_i,
    input  logic [COEF_W-1:0] coef_data_i,
    output logic              coef_ready_o,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              load_err_o,
    input  logic              start_i,
    input  logic              change_i,
    output logic [COEF_W-1:0] filter_phase1_o,
    output logic [COEF_W-1:0] filter_phase2_o,
    output logic [COEF_W-1:0] filter_phase3_o,
    output logic [COEF_W-1:0] filter_phase4_o
);

    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam int GRP_W = $clog2(NUM_GROUP);

    // Symmetric lowpass default, tap order 0..NUM_TAPS-1.
    localparam int DEFAULT_SET [NUM_TAPS] = '{
        3, 2, -3, -13, -23, -16, 26, 102, 189, 247,
        247, 189, 102, 26, -16, -23, -13, -3, 2, 3
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  wr_cnt;
    logic [GRP_W-1:0]  grp;
    logic              act;
    logic [COEF_W-1:0] bank0 [NUM_TAPS];
    logic [COEF_W-1:0] bank1 [NUM_TAPS];

    logic wr_en;
    logic cnt_clr;
    logic commit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        coef_ready_o = 1'b0;
        busy_o       = 1'b0;
        load_done_o  = 1'b0;
        load_err_o   = 1'b0;
        wr_en        = 1'b0;
        cnt_clr      = 1'b0;
        commit       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    cnt_clr = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                coef_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (load_start_i) begin
                    // Restart: the word offered this cycle is accepted and dropped.
                    load_err_o = 1'b1;
                    cnt_clr    = 1'b1;
                end else if (coef_valid_i) begin
                    wr_en = 1'b1;
                    if (wr_cnt == IDX_W'(NUM_TAPS - 1)) state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy_o      = 1'b1;
                load_done_o = 1'b1;
                commit      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the banks are reset explicitly because the default set must be
    // live straight out of reset; this keeps them in flops, not RAM macros.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt <= '0;
            grp    <= '0;
            act    <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                bank0[i] <= COEF_W'(DEFAULT_SET[i]);
                bank1[i] <= '0;
            end
        end else begin
            if (cnt_clr || commit) wr_cnt <= '0;
            else if (wr_en)        wr_cnt <= wr_cnt + IDX_W'(1);

            // Only the shadow bank is ever written.
            if (wr_en) begin
                if (act) bank0[wr_cnt] <= coef_data_i;
                else     bank1[wr_cnt] <= coef_data_i;
            end

            if (commit) act <= ~act;

            if (commit || start_i)                              grp <= '0;
            else if (change_i && grp == GRP_W'(NUM_GROUP - 1)) grp <= '0;
            else if (change_i)                                  grp <= grp + GRP_W'(1);
        end
    end

    logic [IDX_W-1:0]  rd_base;
    logic [COEF_W-1:0] rd_coef [4];

    always_comb begin
        rd_base = IDX_W'(grp) * IDX_W'(NUM_PHASE);
        for (int k = 0; k < 4; k++) begin
            rd_coef[k] = act ? bank1[rd_base + IDX_W'(k)] : bank0[rd_base + IDX_W'(k)];
        end
    end

    assign filter_phase1_o = rd_coef[0];
    assign filter_phase2_o = rd_coef[1];
    assign filter_phase3_o = rd_coef[2];
    assign filter_phase4_o = rd_coef[3];

endmodule
